// File: rtl/counter_slot_arbiter_pkg.sv
// Shared types and helpers for the counter slot arbiter.
//   state_e : arbiter FSM states
//   rr_next : round-robin pointer increment modulo the requester count
package counter_slot_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Next pointer after idx, wrapping at num_req.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num_req);
    return (idx + 1 >= num_req) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/counter_slot_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req_valid bit scanning
// upward from rr_ptr, wrapping modulo NUM_REQ.
//   req_valid : per-requester request flags
//   rr_ptr    : highest-priority index for this scan
//   grant     : one-hot winner (zero when nothing valid)
//   grant_idx : encoded winner index
//   any_valid : at least one request present
module rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any_valid
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  int unsigned idx;
  logic        found;

  assign any_valid = |req_valid;

  // Rotating priority scan; rr_ptr < NUM_REQ so one wrap subtraction suffices.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = 32'(rr_ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[ID_W'(idx)]) begin
        found                 = 1'b1;
        grant[ID_W'(idx)]     = 1'b1;
        grant_idx             = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/counter_slot_arbiter.sv
// Round-robin owner of one shared down-counter. A requester hands in a cycle
// count on valid/ready; the winner's count is loaded, decremented to zero,
// and a one-cycle done pulse is returned to that requester.
//   clk, rst        : clock, synchronous active-high reset
//   req_valid       : per-requester request flags
//   req_cycles      : packed per-requester interval lengths
//   req_ready       : one-hot accept, combinational (no path from req_cycles)
//   done            : registered one-cycle completion pulse to the owner
//   busy            : registered, high whenever not IDLE
//   grant_id        : registered owner index, held while idle
//   count_remaining : registered counter value
module counter_slot_arbiter
  import counter_slot_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*CNT_WIDTH-1:0]   req_cycles,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             done,
  output logic                           busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic [CNT_WIDTH-1:0]           count_remaining
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]        grant_d;
  logic [CNT_WIDTH-1:0]   count_d;
  logic [NUM_REQ-1:0]     done_d;
  logic                   busy_d;

  logic [NUM_REQ-1:0]     pick_grant;
  logic [ID_W-1:0]        pick_idx;
  logic                   pick_any;
  logic [CNT_WIDTH-1:0]   cycles_arr [NUM_REQ];

  // Unpack the flat request-length bus.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign cycles_arr[i] = req_cycles[i*CNT_WIDTH +: CNT_WIDTH];
  end

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_valid (pick_any)
  );

  // Next-state, next-register and ready logic.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_id;
    count_d   = count_remaining;
    done_d    = '0;
    busy_d    = busy;
    req_ready = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          // Ready is withheld during reset so no requester sees a phantom accept.
          req_ready = rst ? '0 : pick_grant;
          grant_d   = pick_idx;
          count_d   = cycles_arr[pick_idx];
          busy_d    = 1'b1;
          if (cycles_arr[pick_idx] != '0) begin
            state_d = COUNT;
          end else begin
            state_d           = DONE;
            done_d[pick_idx]  = 1'b1;
          end
        end
      end
      COUNT: begin
        // Decrement gated so the counter can never wrap.
        if (count_remaining != '0) count_d = count_remaining - CNT_WIDTH'(1);
        if (count_remaining <= CNT_WIDTH'(1)) begin
          state_d          = DONE;
          done_d[grant_id] = 1'b1;
        end
      end
      DONE: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        rr_ptr_d = ID_W'(rr_next(32'(grant_id), NUM_REQ));
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any interval without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      rr_ptr_q        <= '0;
      grant_id        <= '0;
      count_remaining <= '0;
      done            <= '0;
      busy            <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      grant_id        <= grant_d;
      count_remaining <= count_d;
      done            <= done_d;
      busy            <= busy_d;
    end
  end

endmodule

// File: tb/tb_counter_slot_arbiter.sv
// Self-checking bench for counter_slot_arbiter (NUM_REQ=4, CNT_WIDTH=8).
module tb_counter_slot_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_cycles;
  logic [3:0]  req_ready;
  logic [3:0]  done;
  logic        busy;
  logic [1:0]  grant_id;
  logic [7:0]  count_remaining;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  counter_slot_arbiter #(.NUM_REQ(4), .CNT_WIDTH(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_cycles      (req_cycles),
    .req_ready       (req_ready),
    .done            (done),
    .busy            (busy),
    .grant_id        (grant_id),
    .count_remaining (count_remaining)
  );

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] cyc;
    logic [3:0]  rdy;
    logic [3:0]  dn;
    logic        bsy;
    logic [1:0]  gid;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic [3:0] vld, input logic [31:0] cyc,
                              input logic [3:0] rdy, input logic [3:0] dn,
                              input logic bsy, input logic [1:0] gid,
                              input logic [7:0] cnt);
    vec_t v;
    v.vld = vld; v.cyc = cyc; v.rdy = rdy; v.dn = dn;
    v.bsy = bsy; v.gid = gid; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Leaves the bench at a negedge with reset released.
  task automatic apply_reset();
    rst        = 1'b1;
    req_valid  = '0;
    req_cycles = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] fair_exp [4];
    logic [3:0] rr4_exp  [5];
    int         got, dn_cnt, cyc, last_cyc, dn_at, bad;
    logic [3:0] last_rdy, dn_val;
    logic [7:0] cnt_at_done;
    logic       reached, bad_done;

    // Row by row: inputs for the cycle, expected combinational ready and
    // registered outputs visible during that cycle.
    vecs[0]  = mk(4'b0000, 32'h0,        4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0);
    vecs[1]  = mk(4'b0001, 32'h00000003, 4'b0001, 4'b0000, 1'b0, 2'd0, 8'd0);
    vecs[2]  = mk(4'b0000, 32'h00000003, 4'b0000, 4'b0000, 1'b1, 2'd0, 8'd3);
    vecs[3]  = mk(4'b0000, 32'h0,        4'b0000, 4'b0000, 1'b1, 2'd0, 8'd2);
    vecs[4]  = mk(4'b0000, 32'h0,        4'b0000, 4'b0000, 1'b1, 2'd0, 8'd1);
    vecs[5]  = mk(4'b0100, 32'h0,        4'b0000, 4'b0001, 1'b1, 2'd0, 8'd0);
    vecs[6]  = mk(4'b0100, 32'h0,        4'b0100, 4'b0000, 1'b0, 2'd0, 8'd0);
    vecs[7]  = mk(4'b0000, 32'h0,        4'b0000, 4'b0100, 1'b1, 2'd2, 8'd0);
    vecs[8]  = mk(4'b1010, 32'h01000100, 4'b1000, 4'b0000, 1'b0, 2'd2, 8'd0);
    vecs[9]  = mk(4'b1010, 32'h01000100, 4'b0000, 4'b0000, 1'b1, 2'd3, 8'd1);
    vecs[10] = mk(4'b1010, 32'h01000100, 4'b0000, 4'b1000, 1'b1, 2'd3, 8'd0);
    vecs[11] = mk(4'b1010, 32'h01000100, 4'b0010, 4'b0000, 1'b0, 2'd3, 8'd0);
    vecs[12] = mk(4'b1010, 32'h01000100, 4'b0000, 4'b0000, 1'b1, 2'd1, 8'd1);
    vecs[13] = mk(4'b1010, 32'h01000100, 4'b0000, 4'b0010, 1'b1, 2'd1, 8'd0);
    vecs[14] = mk(4'b1010, 32'h01000100, 4'b1000, 4'b0000, 1'b0, 2'd1, 8'd0);
    vecs[15] = mk(4'b0000, 32'h01000100, 4'b0000, 4'b0000, 1'b1, 2'd3, 8'd1);
    vecs[16] = mk(4'b0000, 32'h0,        4'b0000, 4'b1000, 1'b1, 2'd3, 8'd0);
    vecs[17] = mk(4'b0000, 32'h0,        4'b0000, 4'b0000, 1'b0, 2'd3, 8'd0);

    fair_exp = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    rr4_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Directed vector table.
    apply_reset();
    for (int i = 0; i < 18; i++) begin
      req_valid  = vecs[i].vld;
      req_cycles = vecs[i].cyc;
      #1;
      check($sformatf("row%0d_ready", i), 32'(req_ready),       32'(vecs[i].rdy));
      check($sformatf("row%0d_done",  i), 32'(done),            32'(vecs[i].dn));
      check($sformatf("row%0d_busy",  i), 32'(busy),            32'(vecs[i].bsy));
      check($sformatf("row%0d_gid",   i), 32'(grant_id),        32'(vecs[i].gid));
      check($sformatf("row%0d_count", i), 32'(count_remaining), 32'(vecs[i].cnt));
      @(negedge clk);
    end

    // Fairness: requesters 1 and 3 held valid from rr_ptr=0.
    apply_reset();
    req_valid  = 4'b1010;
    req_cycles = 32'h01000100;
    got = 0;
    for (int k = 0; k < 40 && got < 4; k++) begin
      #1;
      if (req_ready != 4'b0000) begin
        check($sformatf("fair_grant%0d", got), 32'(req_ready), 32'(fair_exp[got]));
        got++;
      end
      @(negedge clk);
    end
    check("fair_grant_total", 32'(got), 32'd4);
    req_valid = '0;

    // All four held valid, one cycle each: accepts 3 apart, done 2 after accept.
    apply_reset();
    req_valid  = 4'b1111;
    req_cycles = 32'h01010101;
    got = 0; dn_cnt = 0; cyc = 0; last_cyc = 0; last_rdy = '0;
    for (int k = 0; k < 60 && dn_cnt < 5; k++) begin
      if (got >= 5) req_valid = '0;
      #1;
      if (req_ready != 4'b0000) begin
        check($sformatf("rr4_grant%0d", got), 32'(req_ready), 32'(rr4_exp[got]));
        if (got > 0) check($sformatf("rr4_spacing%0d", got), 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        last_rdy = req_ready;
        got++;
      end
      if (done != 4'b0000) begin
        check($sformatf("rr4_done%0d", dn_cnt), 32'(done), 32'(last_rdy));
        check($sformatf("rr4_done_lat%0d", dn_cnt), 32'(cyc - last_cyc), 32'd2);
        dn_cnt++;
      end
      cyc++;
      @(negedge clk);
    end
    check("rr4_done_total", 32'(dn_cnt), 32'd5);
    req_valid = '0;

    // Maximum interval 255 on requester 0.
    apply_reset();
    req_valid  = 4'b0001;
    req_cycles = 32'h000000FF;
    #1;
    check("max_accept", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    dn_at = 0; bad = 0; dn_val = '0; cnt_at_done = 8'hAA;
    for (int k = 1; k <= 300 && dn_at == 0; k++) begin
      #1;
      if (done != 4'b0000) begin
        dn_at       = k;
        dn_val      = done;
        cnt_at_done = count_remaining;
      end else if (count_remaining != 8'(256 - k) || busy != 1'b1) begin
        bad++;
      end
      @(negedge clk);
    end
    check("max_count_seq_errors", 32'(bad), 32'd0);
    check("max_done_cycle", 32'(dn_at), 32'd256);
    check("max_done_value", 32'(dn_val), 32'h1);
    check("max_count_at_done", 32'(cnt_at_done), 32'd0);
    #1;
    check("max_no_wrap", 32'(count_remaining), 32'd0);
    check("max_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);

    // Reset while counting at 5, then a lone requester-3 request.
    apply_reset();
    req_valid  = 4'b0001;
    req_cycles = 32'h0000000A;
    #1;
    check("rc_accept", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    reached = 1'b0;
    for (int k = 0; k < 20 && !reached; k++) begin
      #1;
      if (count_remaining == 8'd5 && busy) reached = 1'b1;
      else @(negedge clk);
    end
    check("rc_reach5", 32'(reached), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    req_valid  = 4'b1000;
    req_cycles = 32'h02000000;
    #1;
    check("rc_busy",  32'(busy),            32'd0);
    check("rc_done",  32'(done),            32'd0);
    check("rc_count", 32'(count_remaining), 32'd0);
    check("rc_gid",   32'(grant_id),        32'd0);
    check("rc_ready", 32'(req_ready),       32'h8);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("rc_new_gid",   32'(grant_id),        32'd3);
    check("rc_new_count", 32'(count_remaining), 32'd2);
    check("rc_new_busy",  32'(busy),            32'd1);
    bad_done = 1'b0; dn_val = '0;
    for (int k = 0; k < 8; k++) begin
      if (done[0]) bad_done = 1'b1;
      if (done != 4'b0000) dn_val = done;
      @(negedge clk);
      #1;
    end
    check("rc_no_aborted_done", 32'(bad_done), 32'd0);
    check("rc_new_done",        32'(dn_val),   32'h8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_slot_arbiter.md
# counter_slot_arbiter

Arbitrates one shared down-counter between NUM_REQ requesters, each needing a timed interval of a requested number of clock cycles. A requester submits a cycle count on a valid/ready handshake. The block picks one requester round-robin, loads the shared counter, counts it down, and returns a one-cycle done pulse to the owner. It sits between request-generating blocks and the counter datapath, and is the only agent that loads or advances that counter.

## Interface
- NUM_REQ, default 4: number of requesters; legal range 2..16.
- CNT_WIDTH, default 8: width of the requested cycle count and of the counter.
- clk, input, 1: single clock; all state updates on posedge clk.
- rst, input, 1: reset, synchronous and active-high.
- req_valid, input, NUM_REQ: bit i means requester i presents a request.
- req_cycles, input, NUM_REQ*CNT_WIDTH: slice i ([i*CNT_WIDTH +: CNT_WIDTH]) is requester i's interval length.
- req_ready, output, NUM_REQ: one-hot or zero. Bit i means requester i's request is accepted this cycle.
- done, output, NUM_REQ: one-cycle pulse to the requester whose interval finished.
- busy, output, 1: high whenever state is not IDLE.
- grant_id, output, $clog2(NUM_REQ): index of the current owner; holds its last value when idle.
- count_remaining, output, CNT_WIDTH: current counter value.

## Operation
- Registered outputs: done, busy, grant_id, count_remaining.
- req_ready is combinational from the state, rr_ptr and req_valid; it has no combinational path from req_cycles.
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, count_remaining=0, done=0, busy=0. req_ready follows req_valid with rr_ptr=0.
- States:
  - IDLE: if any req_valid bit is set, the winner is the first set bit scanning upward from rr_ptr, modulo NUM_REQ. req_ready[winner]=1 in the same cycle.
  - On accept, latch grant_id=winner and count_remaining=req_cycles[winner]. If req_cycles is nonzero go to COUNT; if it is zero go to DONE.
  - COUNT: decrement count_remaining each cycle. When count_remaining==1, the next state is DONE and the counter reaches 0.
  - DONE: done[grant_id]=1 for exactly this cycle, rr_ptr set to (grant_id+1) mod NUM_REQ, next state IDLE.
- req_ready is 0 in COUNT and DONE. Requests are never accepted while busy.
- A requester may deassert req_valid before ready without penalty; no request is held internally.
- The counter never wraps; the decrement is gated to nonzero values. Maximum interval is 2^CNT_WIDTH-1.
- Reset in any state aborts the interval:
  - no done pulse for the aborted request;
  - rr_ptr returns to 0;
  - the aborted requester must re-request.
- rst has priority over every other event in the same cycle.

## Timing
- Accept at cycle t with N≥1:
  - busy and COUNT from t+1 through t+N;
  - done pulse at t+N+1;
  - IDLE (next accept possible) at t+N+2.
- N=0: done at t+1, next accept at t+2.
- Back-to-back service costs N+2 cycles per request.
- Arbitration is decided and accepted in the same cycle as req_valid: zero-cycle grant latency when idle.

## Structure
- Package counter_slot_arbiter_pkg holds:
  - the state enum (IDLE, COUNT, DONE);
  - a shared rr_next() helper for pointer increment modulo NUM_REQ.
- Sub-module rr_pick: purely combinational round-robin priority selector.
  - Inputs: req_valid, rr_ptr.
  - Outputs: one-hot grant, encoded index, any_valid.
  - Parameterised on NUM_REQ.
- The top level holds the FSM, the count register and the output registers.

## Test plan
- Single request: req_valid=4'b0001 with cycles 3, one cycle after reset → req_ready=0001 that cycle; busy high 4 cycles; done=0001 at accept+4; count_remaining goes 3,2,1,0.
- All four requesters valid with cycles 1 each, held → accepts spaced 3 cycles apart; grant order 0,1,2,3,0; each done pulse 2 cycles after its accept.
- Zero-length interval: cycles 0 on requester 2 → done=0100 at accept+1; busy high exactly 1 cycle.
- Maximum interval: cycles 255, CNT_WIDTH=8 → done at accept+256; count_remaining never wraps to 255 after 0.
- Fairness: requesters 1 and 3 both held valid, starting rr_ptr=0 → grants 1,3,1,3; requester 3 is never starved.
- Reset in COUNT with count_remaining=5 → next cycle busy=0, no done pulse; a new requester-3 request is accepted immediately when it is the only valid request.
